// File: rtl/time_disp_pkg.sv
// Shared constants for the time display scanner: segment codes, scan states
// and the digit index map.
package time_disp_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // Active-low a..g codes, seg[6:0].
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] IDX_SS_ONES  = 3'd0;
  localparam logic [2:0] IDX_SS_TENS  = 3'd1;
  localparam logic [2:0] IDX_SEC_ONES = 3'd2;
  localparam logic [2:0] IDX_SEC_TENS = 3'd3;
  localparam logic [2:0] IDX_MIN_ONES = 3'd4;
  localparam logic [2:0] IDX_MIN_TENS = 3'd5;
  localparam logic [2:0] IDX_HR_ONES  = 3'd6;
  localparam logic [2:0] IDX_HR_TENS  = 3'd7;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // An out-of-range field shows a dash instead of a digit.
  function automatic logic [6:0] digit_seg(input logic ovf, input logic [3:0] d);
    return ovf ? SEG_DASH : seg_code(d);
  endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// Time value bus from the time register into the display scanner.
// Level signals, no handshake: the consumer samples them once per frame.
interface time_display_scan_if;
  logic [13:0] hr_in;
  logic [13:0] min_in;
  logic [13:0] sec_in;
  logic [13:0] small_sec_in;
  logic        setting_enable;
  logic        set_hr_or_min;

  modport master (
    output hr_in, min_in, sec_in, small_sec_in, setting_enable, set_hr_or_min
  );

  modport slave (
    input hr_in, min_in, sec_in, small_sec_in, setting_enable, set_hr_or_min
  );
endinterface

// File: rtl/bin2bcd_99.sv
// Splits a binary field into two decimal digits; values above 99 flag overflow.
module bin2bcd_99 (
  input  logic [13:0] value,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic        overflow
);

  logic [6:0] v;

  assign overflow = (value > 14'd99);
  assign v        = overflow ? 7'd0 : value[6:0];
  assign tens     = 4'(v / 7'd10);
  assign ones     = 4'(v % 7'd10);

endmodule

// File: rtl/time_display_scan.sv
// 8-digit multiplexed common-anode display driver with per-frame snapshot,
// anti-ghost blanking between digits and blinking of the field being set.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 62
) (
  input  logic                  clk,
  input  logic                  reset,
  time_display_scan_if.slave    tif,
  output logic [7:0]            digit_sel,
  output logic [7:0]            seg,
  output logic                  frame_done,
  output state_e                state_dbg
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BLK_W   = $clog2(BLINK_FRAMES + 1);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [13:0]        hr_q, hr_d, min_q, min_d, sec_q, sec_d, ss_q, ss_d;
  logic               set_en_q, set_en_d, set_sel_q, set_sel_d;
  logic [7:0]         digit_sel_q, digit_sel_d, seg_q, seg_d;
  logic               frame_done_q, frame_done_d;

  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o, ss_t, ss_o;
  logic       hr_ovf, min_ovf, sec_ovf, ss_ovf;

  bin2bcd_99 u_hr  (.value(hr_q),  .tens(hr_t),  .ones(hr_o),  .overflow(hr_ovf));
  bin2bcd_99 u_min (.value(min_q), .tens(min_t), .ones(min_o), .overflow(min_ovf));
  bin2bcd_99 u_sec (.value(sec_q), .tens(sec_t), .ones(sec_o), .overflow(sec_ovf));
  bin2bcd_99 u_ss  (.value(ss_q),  .tens(ss_t),  .ones(ss_o),  .overflow(ss_ovf));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    hr_d          = hr_q;
    min_d         = min_q;
    sec_d         = sec_q;
    ss_d          = ss_q;
    set_en_d      = set_en_q;
    set_sel_d     = set_sel_q;
    case (state_q)
      LOAD: begin
        hr_d      = tif.hr_in;
        min_d     = tif.min_in;
        sec_d     = tif.sec_in;
        ss_d      = tif.small_sec_in;
        set_en_d  = tif.setting_enable;
        set_sel_d = tif.set_hr_or_min;
        // Counter holds LOADs seen since the last toggle; this LOAD is the next one.
        if (blink_cnt_q == BLK_W'(BLINK_FRAMES)) begin
          blink_phase_d = ~blink_phase_q;
          blink_cnt_d   = BLK_W'(1);
        end else begin
          blink_cnt_d   = blink_cnt_q + BLK_W'(1);
        end
        idx_d   = IDX_SS_ONES;
        cnt_d   = '0;
        state_d = BLANK;
      end
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
          cnt_d   = '0;
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          cnt_d = '0;
          if (idx_q == IDX_HR_TENS) begin
            state_d = LOAD;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = BLANK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  logic [6:0] digit_code;
  logic       dp_n;
  logic       field_blank;

  always_comb begin
    digit_code   = SEG_BLANK;
    dp_n         = 1'b1;
    field_blank  = 1'b0;
    digit_sel_d  = 8'hFF;
    seg_d        = 8'hFF;
    frame_done_d = 1'b0;
    case (idx_q)
      IDX_SS_ONES:  digit_code = digit_seg(ss_ovf, ss_o);
      IDX_SS_TENS:  digit_code = digit_seg(ss_ovf, ss_t);
      IDX_SEC_ONES: digit_code = digit_seg(sec_ovf, sec_o);
      IDX_SEC_TENS: digit_code = digit_seg(sec_ovf, sec_t);
      IDX_MIN_ONES: digit_code = digit_seg(min_ovf, min_o);
      IDX_MIN_TENS: digit_code = digit_seg(min_ovf, min_t);
      IDX_HR_ONES:  digit_code = digit_seg(hr_ovf, hr_o);
      default:      digit_code = digit_seg(hr_ovf, hr_t);
    endcase
    dp_n = !((idx_q == IDX_SEC_ONES) || (idx_q == IDX_MIN_ONES) || (idx_q == IDX_HR_ONES));
    if (set_en_q && blink_phase_q) begin
      field_blank = set_sel_q ? ((idx_q == IDX_MIN_ONES) || (idx_q == IDX_MIN_TENS))
                              : ((idx_q == IDX_HR_ONES)  || (idx_q == IDX_HR_TENS));
    end
    case (state_q)
      LOAD:  frame_done_d = 1'b1;
      DRIVE: begin
        digit_sel_d = ~(8'h01 << idx_q);
        seg_d       = field_blank ? {1'b1, SEG_BLANK} : {dp_n, digit_code};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      cnt_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hr_q          <= '0;
      min_q         <= '0;
      sec_q         <= '0;
      ss_q          <= '0;
      set_en_q      <= 1'b0;
      set_sel_q     <= 1'b0;
      digit_sel_q   <= 8'hFF;
      seg_q         <= 8'hFF;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hr_q          <= hr_d;
      min_q         <= min_d;
      sec_q         <= sec_d;
      ss_q          <= ss_d;
      set_en_q      <= set_en_d;
      set_sel_q     <= set_sel_d;
      digit_sel_q   <= digit_sel_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign digit_sel  = digit_sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with a short scan (4 on, 2 blank, blink every 2 frames).
module tb_time_display_scan;
  import time_disp_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] digit_sel;
  logic [7:0] seg;
  logic       frame_done;
  state_e     state_dbg;

  time_display_scan_if tif ();

  time_display_scan #(
    .SCAN_DIV(4), .BLANK_CYC(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .tif(tif.slave),
    .digit_sel(digit_sel), .seg(seg), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  exp_seg [8];
  logic [13:0] nx_hr, nx_min, nx_sec, nx_ss;
  logic        nx_se, nx_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [13:0] h, m, s, ss, input logic se, sel);
    tif.hr_in = h; tif.min_in = m; tif.sec_in = s; tif.small_sec_in = ss;
    tif.setting_enable = se; tif.set_hr_or_min = sel;
  endtask

  task automatic set_exp(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    exp_seg[4] = e4; exp_seg[5] = e5; exp_seg[6] = e6; exp_seg[7] = e7;
  endtask

  // Called at the negedge showing frame_done; checks the 48 scan cycles and the
  // next frame_done. At digit mid_idx the nx_* inputs are applied.
  task automatic run_frame(input string tag, input int mid_idx);
    logic [7:0] ds;
    for (int i = 0; i < 8; i++) begin
      if (i == mid_idx) set_inputs(nx_hr, nx_min, nx_sec, nx_ss, nx_se, nx_sel);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        chk($sformatf("%s_blank%0d", tag, i), {15'd0, frame_done, digit_sel, seg}, {15'd0, 1'b0, 16'hFFFF});
      end
      ds = ~(8'h01 << i);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("%s_drive%0d", tag, i), {15'd0, frame_done, digit_sel, seg}, {15'd0, 1'b0, ds, exp_seg[i]});
      end
    end
    @(negedge clk);
    chk({tag, "_frame_done"}, {15'd0, frame_done, digit_sel, seg}, {15'd0, 1'b1, 16'hFFFF});
  endtask

  initial begin
    reset = 1'b0;
    set_inputs(14'd12, 14'd34, 14'd56, 14'd78, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_digit_sel", {24'd0, digit_sel}, 32'h0000_00FF);
    chk("reset_seg", {24'd0, seg}, 32'h0000_00FF);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_state", {30'd0, state_dbg}, {30'd0, LOAD});
    reset = 1'b1;
    @(negedge clk);
    chk("first_pulse", {15'd0, frame_done, digit_sel, seg}, {15'd0, 1'b1, 16'hFFFF});

    // Frame 1: normal 12:34:56.78; sec changes to 7 at idx 3 (snapshot holds 56)
    set_exp(8'h80, 8'hF8, 8'h02, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9);
    nx_hr = 14'd12; nx_min = 14'd34; nx_sec = 14'd7; nx_ss = 14'd78; nx_se = 1'b0; nx_sel = 1'b0;
    run_frame("normal", 3);

    // Frame 2: sec = 07; min goes to 100 for the next frame
    set_exp(8'h80, 8'hF8, 8'h78, 8'hC0, 8'h19, 8'hB0, 8'h24, 8'hF9);
    nx_min = 14'd100;
    run_frame("snapshot", 0);

    // Frame 3: min overflow dashes; then all zero
    set_exp(8'h80, 8'hF8, 8'h78, 8'hC0, 8'h3F, 8'hBF, 8'h24, 8'hF9);
    nx_hr = 14'd0; nx_min = 14'd0; nx_sec = 14'd0; nx_ss = 14'd0;
    run_frame("overflow", 5);

    // Frame 4 (blink phase 1, but setting off): all zero; then setting min
    set_exp(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);
    nx_hr = 14'd12; nx_min = 14'd34; nx_sec = 14'd56; nx_ss = 14'd78; nx_se = 1'b1; nx_sel = 1'b1;
    run_frame("zero", 4);

    // Frames 5-6 phase 0: shown
    set_exp(8'h80, 8'hF8, 8'h02, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9);
    run_frame("blink_f5", -1);
    run_frame("blink_f6", -1);
    // Frames 7-8 phase 1: min blanked; select switches to hr mid frame 8
    exp_seg[4] = 8'hFF; exp_seg[5] = 8'hFF;
    run_frame("blink_f7", -1);
    nx_sel = 1'b0;
    run_frame("blink_f8", 2);
    // Frames 9-10 phase 0: shown; frame 11 phase 1: hr blanked
    exp_seg[4] = 8'h19; exp_seg[5] = 8'hB0;
    run_frame("blink_f9", -1);
    run_frame("blink_f10", -1);
    exp_seg[6] = 8'hFF; exp_seg[7] = 8'hFF;
    run_frame("blink_f11", -1);

    // Reset mid-DRIVE of idx 0
    repeat (4) @(negedge clk);
    chk("pre_reset_drive", {16'd0, digit_sel, seg}, {16'd0, 8'hFE, 8'h80});
    reset = 1'b0;
    #1;
    chk("async_reset_out", {15'd0, frame_done, digit_sel, seg}, {15'd0, 1'b0, 16'hFFFF});
    chk("async_reset_state", {30'd0, state_dbg}, {30'd0, LOAD});
    set_inputs(14'd12, 14'd34, 14'd56, 14'd78, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_pulse", {15'd0, frame_done, digit_sel, seg}, {15'd0, 1'b1, 16'hFFFF});
    set_exp(8'h80, 8'hF8, 8'h02, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9);
    run_frame("rst_f1", -1);
    run_frame("rst_f2", -1);
    exp_seg[4] = 8'hFF; exp_seg[5] = 8'hFF;
    run_frame("rst_f3", -1);
    run_frame("rst_f4", -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
